// File: rtl/ser_pkg.sv
// Shared constants for the buffered serial port: bus register map, status
// bit positions, baud table and the receiver/transmitter state encodings.
package ser_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_IE   = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_SPACE = 1;
    localparam int ST_OVR      = 2;
    localparam int ST_FERR     = 3;
    localparam int ST_TX_IDLE  = 4;

    localparam int CTRL_CLR_OVR  = 2;
    localparam int CTRL_CLR_FERR = 3;

    // 9600 baud is the power-up rate.
    localparam logic [2:0] BAUD_RESET_CODE = 3'd2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        int unsigned rate;
        case (code)
            3'd0:    rate = 2400;
            3'd1:    rate = 4800;
            3'd2:    rate = 9600;
            3'd3:    rate = 19200;
            3'd4:    rate = 31250;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Clock cycles per bit, rounded to nearest.
    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input logic [2:0] code);
        int unsigned rate;
        rate = baud_rate(code);
        return 16'((clk_freq + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/ser_sync_fifo.sv
// Byte-wide show-ahead FIFO of 2**AW entries with an occupancy count.
// A push on a full FIFO is only taken when a pop frees a slot in the same cycle.
module ser_sync_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level_q == '0);
    assign full    = level_q[AW];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ser_fifo.sv
// Buffered 8N1 UART on the word I/O bus: RX/TX FIFOs, selectable baud rate,
// sticky overrun/framing flags and a level interrupt.
module ser_fifo
    import ser_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int          RX_AW    = 4,
    parameter int          TX_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);

    localparam logic [15:0] RESET_BIT_LEN = baud_div(CLK_FREQ, BAUD_RESET_CODE);

    logic [15:0] bit_len_q, bit_len_d;
    logic [2:0]  ie_q, ie_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        irq_q, irq_d;

    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;

    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q, rx_len_q;
    logic [2:0]  rx_idx_q;
    logic [7:0]  rx_shift_q;
    logic        rx_push_q, rx_stop_bad_q;

    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q, tx_len_q;
    logic [2:0]  tx_idx_q;
    logic [7:0]  tx_shift_q;
    logic        txd_q;

    logic [7:0]       rx_dout, tx_dout;
    logic [RX_AW:0]   rx_level;
    logic [TX_AW:0]   tx_level;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             rx_pop, tx_push, tx_load, bus_rd, bus_wr, tx_idle;
    logic             unused_data_in;

    assign unused_data_in = ^data_in[31:8];
    assign ack     = stb;
    assign irq     = irq_q;
    assign txd     = txd_q;
    assign bus_rd  = stb & ~we;
    assign bus_wr  = stb & we;
    assign rx_pop  = bus_rd & (addr == ADDR_DATA) & ~rx_empty;
    assign tx_push = bus_wr & (addr == ADDR_DATA) & ~tx_full;
    assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
    // A new frame starts from idle, or straight out of a finished stop bit.
    assign tx_load = ~tx_empty & ((tx_state_q == TX_IDLE) ||
                                  (tx_state_q == TX_STOP && tx_cnt_q == '0));

    ser_sync_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_q), .din(rx_shift_q), .pop(rx_pop),
        .dout(rx_dout), .level(rx_level), .full(rx_full), .empty(rx_empty)
    );

    ser_sync_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .din(data_in[7:0]), .pop(tx_load),
        .dout(tx_dout), .level(tx_level), .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        data_out = '0;
        case (addr)
            ADDR_DATA: if (!rx_empty) data_out[7:0] = rx_dout;
            ADDR_STAT: begin
                data_out[ST_RX_AVAIL] = ~rx_empty;
                data_out[ST_TX_SPACE] = ~tx_full;
                data_out[ST_OVR]      = ovr_q;
                data_out[ST_FERR]     = ferr_q;
                data_out[ST_TX_IDLE]  = tx_idle;
                data_out[15:8]        = 8'(rx_level);
            end
            ADDR_IE:   data_out[2:0] = ie_q;
            default:   data_out[7:0] = 8'(tx_level);
        endcase
    end

    // Hardware set wins over a simultaneous software clear so no event is lost.
    always_comb begin
        bit_len_d = bit_len_q;
        ie_d      = ie_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        if (bus_wr && addr == ADDR_STAT) bit_len_d = baud_div(CLK_FREQ, data_in[2:0]);
        if (bus_wr && addr == ADDR_IE)   ie_d = data_in[2:0];
        if (bus_wr && addr == ADDR_CTRL) begin
            if (data_in[CTRL_CLR_OVR])  ovr_d  = 1'b0;
            if (data_in[CTRL_CLR_FERR]) ferr_d = 1'b0;
        end
        if (rx_push_q && rx_full && !rx_pop) ovr_d  = 1'b1;
        if (rx_push_q && rx_stop_bad_q)      ferr_d = 1'b1;
        irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & ~tx_full) | (ie_q[2] & (ovr_q | ferr_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_len_q  <= RESET_BIT_LEN;
            ie_q       <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            bit_len_q  <= bit_len_d;
            ie_q       <= ie_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Receiver: counts down to mid-bit sample points using the rate latched at the start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_len_q      <= '0;
            rx_idx_q      <= '0;
            rx_shift_q    <= '0;
            rx_push_q     <= 1'b0;
            rx_stop_bad_q <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        rx_len_q   <= bit_len_q;
                        rx_cnt_q   <= bit_len_q >> 1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rxd_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= rx_len_q - 16'd1;
                            rx_idx_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_len_q - 16'd1;
                        rx_idx_q   <= rx_idx_q + 3'd1;
                        if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_q == '0) begin
                        rx_push_q     <= 1'b1;
                        rx_stop_bad_q <= ~rxd_sync_q;
                        rx_state_q    <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // Transmitter: each bit is held for tx_len_q cycles; frames chain without gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_len_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        txd_q      <= tx_shift_q[0];
                        tx_cnt_q   <= tx_len_q - 16'd1;
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= tx_len_q - 16'd1;
                        if (tx_idx_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (tx_load) begin
                        tx_shift_q <= tx_dout;
                        tx_len_q   <= bit_len_q;
                        tx_cnt_q   <= bit_len_q - 16'd1;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end else if (tx_state_q == TX_STOP) begin
                        if (tx_cnt_q == '0) tx_state_q <= TX_IDLE;
                        else                tx_cnt_q   <= tx_cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_fifo.sv
// Directed bench for ser_fifo at a 25 MHz clock (115200 baud -> 217 cycles per bit).
module tb_ser_fifo;

    localparam int BL = 217;
    localparam int HB = 108;

    logic        clk = 1'b0;
    logic        rst, stb, we, lb, rxd_drv;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out, rd;
    logic        ack, irq, rxd, txd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign rxd = lb ? txd : rxd_drv;

    ser_fifo #(.CLK_FREQ(25000000), .RX_AW(4), .TX_AW(4)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .irq(irq), .rxd(rxd), .txd(txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        wait_cycles(1);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        #1 d = data_out;
        wait_cycles(1);
        stb = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        wait_cycles(BL);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            wait_cycles(BL);
        end
        rxd_drv = stop;
        wait_cycles(BL);
        rxd_drv = 1'b1;
        wait_cycles(BL);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] exp_b;
        logic       seen;
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0; lb = 1'b0; rxd_drv = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);

        // Reset state
        bus_read(2'd1, rd);
        check("reset_status", rd, 32'h0000_0012);
        check("reset_txd", {31'b0, txd}, 32'd1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        bus_read(2'd2, rd);
        check("reset_ie", rd, 32'd0);
        stb = 1'b1; we = 1'b0; addr = 2'd0;
        #1 check("ack_follows_stb", {31'b0, ack}, 32'd1);
        check("read_empty_rx", data_out, 32'd0);
        wait_cycles(1);
        stb = 1'b0;

        // Transmit 0x55 at 115200 baud, sampling mid-bit
        bus_write(2'd1, 32'd7);
        bus_write(2'd0, 32'h55);
        frame = {1'b1, 8'h55, 1'b0};
        wait_cycles(1);
        for (int b = 0; b < 10; b++) begin
            wait_cycles(HB);
            check($sformatf("tx_bit%0d", b), {31'b0, txd}, {31'b0, frame[b]});
            if (b < 9) wait_cycles(BL - HB);
        end
        wait_cycles(BL - HB - 1);
        bus_read(2'd1, rd);
        check("tx_idle_before_end", {31'b0, rd[4]}, 32'd0);
        bus_read(2'd1, rd);
        check("tx_idle_after_frame", {31'b0, rd[4]}, 32'd1);

        // Loopback of three back-to-back bytes
        lb = 1'b1;
        bus_write(2'd0, 32'hA5);
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'hFF);
        bus_read(2'd3, rd);
        check("tx_level_after_burst", rd, 32'd2);
        wait_cycles(3 * 10 * BL + 200);
        lb = 1'b0;
        bus_read(2'd1, rd);
        check("lb_rx_level", rd[15:8], 32'd3);
        bus_read(2'd0, rd); check("lb_byte0", rd, 32'hA5);
        bus_read(2'd0, rd); check("lb_byte1", rd, 32'h3C);
        bus_read(2'd0, rd); check("lb_byte2", rd, 32'hFF);
        bus_read(2'd0, rd); check("lb_empty_read", rd, 32'h00);
        bus_read(2'd1, rd);
        check("lb_rx_avail_clear", {31'b0, rd[0]}, 32'd0);

        // Overrun: 17 frames into a 16-deep RX FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i * 37 + 5), 1'b1);
        wait_cycles(4);
        bus_read(2'd1, rd);
        check("ovr_level", rd[15:8], 32'd16);
        check("ovr_flag", {31'b0, rd[2]}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'(i * 37 + 5);
            bus_read(2'd0, rd);
            check($sformatf("ovr_byte%0d", i), rd, {24'b0, exp_b});
        end
        bus_write(2'd3, 32'h4);
        bus_read(2'd1, rd);
        check("ovr_cleared", rd, 32'h0000_0012);

        // Framing error: byte still stored
        send_frame(8'h81, 1'b0);
        wait_cycles(4);
        bus_read(2'd1, rd);
        check("ferr_status", rd, 32'h0000_011B);
        bus_read(2'd0, rd);
        check("ferr_byte", rd, 32'h81);
        bus_write(2'd3, 32'h8);
        bus_read(2'd1, rd);
        check("ferr_cleared", {31'b0, rd[3]}, 32'd0);

        // Short low glitch is rejected as a false start
        rxd_drv = 1'b0;
        wait_cycles(65);
        rxd_drv = 1'b1;
        wait_cycles(3 * BL);
        bus_read(2'd1, rd);
        check("glitch_no_push", rd[15:8], 32'd0);

        // Receive interrupt timing
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        check("ie_readback", rd, 32'd1);
        wait_cycles(2);
        check("irq_idle", {31'b0, irq}, 32'd0);
        fork
            send_frame(8'h5A, 1'b1);
        join_none
        addr = 2'd1;
        seen = 1'b0;
        for (int c = 0; c < 12 * BL && !seen; c++) begin
            wait_cycles(1);
            if (data_out[0]) seen = 1'b1;
        end
        check("irq_frame_arrived", {31'b0, seen}, 32'd1);
        check("irq_low_at_push", {31'b0, irq}, 32'd0);
        wait_cycles(1);
        check("irq_high_after_push", {31'b0, irq}, 32'd1);
        wait_cycles(3 * BL);
        stb = 1'b1; we = 1'b0; addr = 2'd0;
        #1 check("irq_byte", data_out, 32'h5A);
        wait_cycles(1);
        stb = 1'b0;
        check("irq_still_high_at_pop", {31'b0, irq}, 32'd1);
        wait_cycles(1);
        check("irq_cleared_after_pop", {31'b0, irq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_fifo.md
Name: ser_fifo

Overview:
Buffered serial line interface (8N1 UART) for the RISC5 I/O bus, generalised over the existing single-byte serial port. It adds parametrised RX/TX FIFOs, a baud table derived from the clock frequency, and sticky overrun/framing error flags. It also adds interrupt enables with a level irq output. It sits on the same stb/we/addr word bus as the other I/O devices.

Parameters:
CLK_FREQ, 50000000, system clock in Hz; baud divisors are computed from it at elaboration.
RX_AW, 4, log2 RX FIFO depth (16 entries).
TX_AW, 4, log2 TX FIFO depth (16 entries).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
stb  in  1  bus strobe, one cycle per access
we  in  1  write enable
addr  in  2  register select
data_in  in  32  write data
data_out  out  32  read data, combinational; unused bits 0
ack  out  1  equals stb; zero wait states
irq  out  1  level interrupt, registered
rxd  in  1  serial input, asynchronous
txd  out  1  serial output, idle high

Behaviour:
- Reset values: txd=1, irq=0, both FIFOs empty, ovr=0, ferr=0, ie=000, bit_len=round(CLK_FREQ/9600) (5208 at 50 MHz).
- Rounding rule for every divisor: (CLK_FREQ + baud/2) / baud, 16 bits.
- addr 0, read: returns {24'b0, RX head}; pops RX if not empty. When RX is empty it returns 0 and does not pop.
- addr 0, write: pushes data_in[7:0] into TX. The byte is silently dropped if TX is full.
- addr 1, read: status. bit0 rx_avail, bit1 tx_space, bit2 ovr, bit3 ferr, bit4 tx_idle (TX empty and shifter idle), [15:8] RX level zero-extended.
- addr 1, write: data_in[2:0] selects the baud rate.
  - Codes 0..7 = 2400, 4800, 9600, 19200, 31250, 38400, 57600, 115200.
  - At 50 MHz the divisors are 20833, 10417, 5208, 2604, 1600, 1302, 868, 434.
- addr 2, read/write: ie[2:0]; read returns {29'b0, ie}.
- addr 3, write: data_in[2]=1 clears ovr; data_in[3]=1 clears ferr.
- addr 3, read: TX level [7:0].
- irq is registered one cycle after its sources: irq <= (ie0 & rx_avail) | (ie1 & tx_space) | (ie2 & (ovr|ferr)).
- Receiver:
  - rxd passes through a 2-flop synchroniser; states IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of the synchronised rxd; the receiver latches bit_len at that point.
  - START samples at bit_len/2. A sample of 1 means a false start: return to IDLE with no push.
  - DATA takes 8 samples at bit_len intervals, LSB first.
  - STOP samples once more. The byte is pushed regardless of the stop sample; a stop sample of 0 sets ferr. The receiver then returns to IDLE.
  - After the stop sample, the receiver re-arms within the same cycle.
- Transmitter:
  - States IDLE, START, DATA, STOP.
  - In IDLE with TX not empty, it pops the head and latches bit_len, then runs START (0), 8 data bits LSB first, and STOP (1). Each bit lasts bit_len cycles.
  - A frame is 10*bit_len cycles. Back-to-back frames have no idle gap.
- A bit_len change never disturbs a frame in progress; it applies from the next frame start in each direction.
- RX push while RX full: the byte is dropped and ovr is set.
  - A push and a CPU pop in the same cycle on a full FIFO are both accepted, with no ovr.
  - A push into an empty FIFO in the same cycle as a read returns 0; the pushed byte is kept.
- FIFOs are show-ahead. Level counts run 0..2^AW, and pointers wrap modulo 2^AW.
- Reset mid-frame: txd goes to 1 on the next edge, the partial RX byte is discarded, and FIFO contents are lost.

Decomposition:
- Package ser_pkg holds:
  - register address constants;
  - status bit indices;
  - baud code table and a divisor function of CLK_FREQ;
  - RX/TX state enums.
- Sub-module ser_sync_fifo (parameter AW, width 8, show-ahead, level output) is instantiated twice.
- The receiver and transmitter FSMs stay in ser_fifo.

Test Plan:
- Reset, then read addr 1 -> 0x00000012 (tx_space, tx_idle); txd=1; irq=0.
- Set baud code 7, write 0x55 to addr 0 -> txd low for 434 cycles, then bits 1,0,1,0,1,0,1,0 each 434 cycles, then high. tx_idle rises after 4340 cycles.
- Loopback txd->rxd, write 0xA5, 0x3C, 0xFF back-to-back -> RX level 3. Reads return A5, 3C, FF, then 00 with RX empty.
- Drive 17 frames into RX without reading -> level 16, ovr=1. The first 16 bytes are intact. Write addr 3 with 0x4 -> ovr=0.
- Frame 0x81 with stop bit 0 -> byte 0x81 stored, ferr=1. A 0.3-bit low glitch on rxd -> no push.
- ie=001 with an empty RX, then one frame -> irq rises 1 cycle after the push. The read pop clears irq on the following cycle.
